// File: rtl/rgb_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_gen
//  Description : Three-channel (R/G/B) PWM generator for the RGB LED driver.
//                Duty registers are double-buffered and transferred to the
//                active set only at a PWM period boundary, so the outputs
//                never glitch. Control (enable, prescaler) applies at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pwm_gen #(
   parameter int DUTY_W  = 8,
   parameter int PRESC_W = 8
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [1:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic        red_pwm,
   output logic        green_pwm,
   output logic        blue_pwm,
   output logic        period_start
);

   // Last period count value: 2^DUTY_W-2, so one period is 2^DUTY_W-1 ticks.
   localparam logic [DUTY_W-1:0]  c_PER_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};
   localparam logic [DUTY_W-1:0]  c_ONE_D    = {{(DUTY_W-1){1'b0}}, 1'b1};
   localparam logic [PRESC_W-1:0] c_ONE_P    = {{(PRESC_W-1){1'b0}}, 1'b1};

   logic [DUTY_W-1:0]  r_pend_r, r_pend_g, r_pend_b;
   logic [DUTY_W-1:0]  r_act_r,  r_act_g,  r_act_b;
   logic               r_en;
   logic               r_en_d;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_presc_cnt;
   logic [DUTY_W-1:0]  r_per_cnt;

   logic w_tick;
   logic w_per_last;
   logic w_bound;
   logic w_unused;

   assign w_tick     = r_en && (r_presc_cnt == r_presc);
   assign w_per_last = (r_per_cnt == c_PER_LAST);
   // A period boundary: wrap of the period counter, or first enabled cycle.
   assign w_bound    = r_en && ((w_tick && w_per_last) || !r_en_d);

   assign period_start = w_bound;
   assign w_unused     = ^wr_data;

   // Register write port: pending duties plus the live control register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_pend_r <= '0;
         r_pend_g <= '0;
         r_pend_b <= '0;
         r_en     <= 1'b0;
         r_presc  <= '0;
      end else if (wr_en) begin
         case (wr_addr)
            2'd0:    r_pend_r <= wr_data[DUTY_W-1:0];
            2'd1:    r_pend_g <= wr_data[DUTY_W-1:0];
            2'd2:    r_pend_b <= wr_data[DUTY_W-1:0];
            default: begin
               r_en    <= wr_data[0];
               r_presc <= wr_data[PRESC_W+7:8];
            end
         endcase
      end
   end

   // Prescaler: counts 0..presc; a count above a newly lowered presc wraps silently.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_presc_cnt <= '0;
      end else if (!r_en) begin
         r_presc_cnt <= '0;
      end else if (w_tick || (r_presc_cnt > r_presc)) begin
         r_presc_cnt <= '0;
      end else begin
         r_presc_cnt <= r_presc_cnt + c_ONE_P;
      end
   end

   // Period counter: advances once per tick over 0..2^DUTY_W-2.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_per_cnt <= '0;
      end else if (!r_en) begin
         r_per_cnt <= '0;
      end else if (w_tick) begin
         r_per_cnt <= w_per_last ? '0 : (r_per_cnt + c_ONE_D);
      end
   end

   // Active duties follow pending while disabled, else load only at a boundary.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_act_r <= '0;
         r_act_g <= '0;
         r_act_b <= '0;
      end else if (!r_en || w_bound) begin
         r_act_r <= r_pend_r;
         r_act_g <= r_pend_g;
         r_act_b <= r_pend_b;
      end
   end

   // Registered compare outputs and enable history for rise detection.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         red_pwm   <= 1'b0;
         green_pwm <= 1'b0;
         blue_pwm  <= 1'b0;
         r_en_d    <= 1'b0;
      end else begin
         red_pwm   <= r_en && (r_per_cnt < r_act_r);
         green_pwm <= r_en && (r_per_cnt < r_act_g);
         blue_pwm  <= r_en && (r_per_cnt < r_act_b);
         r_en_d    <= r_en;
      end
   end

   // Readback of the pending (shadow) registers; unused bits read as zero.
   always_comb begin
      rd_data = '0;
      case (rd_addr)
         2'd0:    rd_data[DUTY_W-1:0] = r_pend_r;
         2'd1:    rd_data[DUTY_W-1:0] = r_pend_g;
         2'd2:    rd_data[DUTY_W-1:0] = r_pend_b;
         default: begin
            rd_data[0]           = r_en;
            rd_data[PRESC_W+7:8] = r_presc;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pwm_gen
//  Description : Self-checking bench for rgb_pwm_gen with a cycle reference
//                model plus period-level duty / spacing measurements.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_gen;

   localparam int PER_LAST = 254;

   logic        HCLK;
   logic        HRESETn;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic        red_pwm, green_pwm, blue_pwm, period_start;

   rgb_pwm_gen #(.DUTY_W(8), .PRESC_W(8)) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .red_pwm     (red_pwm),
      .green_pwm   (green_pwm),
      .blue_pwm    (blue_pwm),
      .period_start(period_start)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit m_en, m_en_prev;
   int m_presc, m_pc, m_per;
   int m_pend[3];
   int m_act[3];
   bit m_pwm[3];

   logic s_r, s_g, s_b, s_ps;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_en_prev = 0; m_presc = 0; m_pc = 0; m_per = 0;
      for (int i = 0; i < 3; i++) begin
         m_pend[i] = 0; m_act[i] = 0; m_pwm[i] = 0;
      end
   endtask

   // Sample at the falling edge and compare every output against the model.
   task automatic sample();
      logic [15:0] exp_rd;
      bit          exp_ps;
      @(negedge HCLK);
      s_r = red_pwm; s_g = green_pwm; s_b = blue_pwm; s_ps = period_start;
      exp_ps = m_en && (!m_en_prev || (m_pc == m_presc && m_per == PER_LAST));
      if (rd_addr == 2'd3) exp_rd = {8'(m_presc), 7'b0, m_en};
      else                 exp_rd = 16'(m_pend[rd_addr]);
      chk("red_pwm",      {15'b0, s_r},  {15'b0, m_pwm[0]});
      chk("green_pwm",    {15'b0, s_g},  {15'b0, m_pwm[1]});
      chk("blue_pwm",     {15'b0, s_b},  {15'b0, m_pwm[2]});
      chk("period_start", {15'b0, s_ps}, {15'b0, exp_ps});
      chk("rd_data",      rd_data,       exp_rd);
   endtask

   // Rising edge: advance the model with the inputs the DUT just sampled.
   task automatic advance();
      bit tick, bnd;
      @(posedge HCLK);
      tick = m_en && (m_pc == m_presc);
      bnd  = m_en && (!m_en_prev || (tick && m_per == PER_LAST));
      for (int i = 0; i < 3; i++) m_pwm[i] = m_en && (m_per < m_act[i]);
      for (int i = 0; i < 3; i++) if (!m_en || bnd) m_act[i] = m_pend[i];
      if (!m_en) begin
         m_pc = 0; m_per = 0;
      end else begin
         m_pc = (tick || m_pc > m_presc) ? 0 : m_pc + 1;
         if (tick) m_per = (m_per + 1) % (PER_LAST + 1);
      end
      m_en_prev = m_en;
      if (wr_en) begin
         if (wr_addr == 2'd3) begin
            m_en = wr_data[0]; m_presc = int'(wr_data[15:8]);
         end else begin
            m_pend[wr_addr] = int'(wr_data[7:0]);
         end
      end
      #1;
      wr_en = 1'b0;
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
   endtask

   // Measure one full period from a boundary: spacing to the next boundary and
   // high cycles per channel (aligned for the one-cycle output register).
   // Optionally issue a write at cycle offset wa_off from the start boundary.
   task automatic measure(input int wa_off, input logic [1:0] wa_addr,
                          input logic [15:0] wa_data,
                          output int gap, output int hr, output int hg, output int hb);
      int k;
      k = -1; gap = 0; hr = 0; hg = 0; hb = 0;
      for (int i = 0; i < 6000; i++) begin
         sample();
         if (k < 0) begin
            if (s_ps) k = 0;
         end else begin
            k++;
         end
         if (k >= 0 && k == wa_off) wr(wa_addr, wa_data);
         if (k >= 2) begin
            hr += int'(s_r); hg += int'(s_g); hb += int'(s_b);
         end
         if (k >= 1 && gap == 0 && s_ps) gap = k;
         advance();
         if (gap != 0 && k == gap + 1) return;
      end
      n_cmp++;
      n_bad++;
      $error("FAIL measure_timeout observed=no_boundary expected=boundary");
   endtask

   int gap, hr, hg, hb;

   initial begin
      HRESETn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      model_reset();

      // reset state, all read addresses
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         sample();
         @(posedge HCLK);
      end
      #1;
      HRESETn = 1'b1;
      rd_addr = 2'd0;

      // basic duty, presc 0
      wr(0, 16'd64);  cyc();
      wr(1, 16'd128); cyc();
      wr(2, 16'd255); cyc();
      wr(3, 16'h0001); cyc();
      sample();
      chk("en_rise_ps", {15'b0, s_ps}, 16'd1);
      advance();
      measure(-1, 2'd0, 16'd0, gap, hr, hg, hb);
      chk("basic_gap", 16'(gap), 16'd255);
      chk("basic_red", 16'(hr), 16'd64);
      chk("basic_grn", 16'(hg), 16'd128);
      chk("basic_blu", 16'(hb), 16'd255);

      // prescaler 3, red 10
      wr(0, 16'd10); cyc();
      wr(3, 16'h0301); cyc();
      measure(-1, 2'd0, 16'd0, gap, hr, hg, hb);
      chk("presc_gap", 16'(gap), 16'd1020);
      chk("presc_red", 16'(hr), 16'd40);
      chk("presc_blu", 16'(hb), 16'd1020);

      // glitch-free update mid-period
      wr(0, 16'd64); cyc();
      wr(3, 16'h0001); cyc();
      measure(-1, 2'd0, 16'd0, gap, hr, hg, hb);
      measure(100, 2'd0, 16'd200, gap, hr, hg, hb);
      chk("glitch_old_red", 16'(hr), 16'd64);
      chk("glitch_gap", 16'(gap), 16'd255);
      sample();
      chk("glitch_rd", rd_data, 16'd200);
      advance();
      measure(-1, 2'd0, 16'd0, gap, hr, hg, hb);
      chk("glitch_new_red", 16'(hr), 16'd200);

      // write on the exact boundary edge
      measure(0, 2'd1, 16'd32, gap, hr, hg, hb);
      chk("collide_old_grn", 16'(hg), 16'd128);
      measure(-1, 2'd0, 16'd0, gap, hr, hg, hb);
      chk("collide_new_grn", 16'(hg), 16'd32);

      // enable toggle mid-period
      for (int i = 0; i < 50; i++) cyc();
      wr(3, 16'h0000); cyc();
      cyc();
      sample();
      chk("dis_blu", {15'b0, s_b}, 16'd0);
      chk("dis_red", {15'b0, s_r}, 16'd0);
      advance();
      wr(3, 16'h0001); cyc();
      sample();
      chk("reen_ps", {15'b0, s_ps}, 16'd1);
      advance();
      sample();
      chk("reen_red", {15'b0, s_r}, 16'd1);
      chk("reen_grn", {15'b0, s_g}, 16'd1);
      advance();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rd_addr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            logic [1:0]  a;
            logic [15:0] d;
            a = 2'($urandom_range(0, 3));
            if (a == 2'd3) begin
               d = {8'($urandom_range(0, 3)), 7'b0, 1'($urandom_range(0, 5) != 0)};
            end else begin
               case ($urandom_range(0, 3))
                  0:       d = 16'd0;
                  1:       d = 16'd255;
                  default: d = 16'($urandom_range(0, 255));
               endcase
            end
            wr(a, d);
         end
         cyc();
      end

      // asynchronous reset mid-period
      rd_addr = 2'd2;
      wr(2, 16'd255); cyc();
      wr(3, 16'h0001); cyc();
      for (int i = 0; i < 300; i++) cyc();
      #2;
      HRESETn = 1'b0;
      #1;
      chk("arst_blu", {15'b0, blue_pwm}, 16'd0);
      chk("arst_red", {15'b0, red_pwm}, 16'd0);
      chk("arst_ps",  {15'b0, period_start}, 16'd0);
      chk("arst_rd",  rd_data, 16'd0);
      model_reset();
      @(posedge HCLK);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      for (int i = 0; i < 5; i++) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
